// File: rtl/l2_way_array_if.sv
// l2_way_array_if
//   Bus between an L2 cache controller and the tag/valid/dirty/LRU way array.
//
//   Valid/ready contract: the array accepts read and load only in cycles where
//   ready is high. In those cycles, a read sampled high on a rising edge
//   produces dataout one edge later. A load sampled high writes on that same
//   edge. While ready is low, read, load and flush are ignored and dataout
//   holds its value.
//
//   Signals (the master is the controller, the slave is the array):
//     flush   m->s  1                  request a clearing sweep of every entry
//     ready   s->m  1                  array accepts read/load
//     read    m->s  1                  capture a read of rindex
//     rindex  m->s  s_index            read set index
//     load    m->s  num_ways           per-way write enable
//     windex  m->s  s_index            write set index
//     wmask   m->s  width/gran         lane enables for datain
//     datain  m->s  width              write data, shared by all ways
//     dataout s->m  num_ways*width     registered read data, way w at [w*width +: width]
interface l2_way_array_if #(
   parameter int s_index  = 3,
   parameter int width    = 32,
   parameter int num_ways = 4,
   parameter int gran     = 8
);
   localparam int num_lanes = width / gran;

   logic                        flush;
   logic                        ready;
   logic                        read;
   logic [s_index-1:0]          rindex;
   logic [num_ways-1:0]         load;
   logic [s_index-1:0]          windex;
   logic [num_lanes-1:0]        wmask;
   logic [width-1:0]            datain;
   logic [num_ways*width-1:0]   dataout;

   modport master (
      output flush, read, rindex, load, windex, wmask, datain,
      input  ready, dataout
   );

   modport slave (
      input  flush, read, rindex, load, windex, wmask, datain,
      output ready, dataout
   );
endinterface

// File: rtl/l2_way_array.sv
// l2_way_array
//   Multi-way register array holding L2 tag, valid, dirty and LRU state.
//   There are num_ways independent ways of 2**s_index entries each. All ways
//   share one read index and one write index. Each way has its own write
//   enable, and writes are masked in gran-bit lanes. Reads are registered. A
//   read that hits the set being written in the same cycle returns the merged
//   post-write value. After reset or a flush, a sweep clears one set per cycle
//   across all ways. ready is low until the sweep finishes.
//
//   Ports:
//     clk        clock
//     rst        synchronous active-high reset
//     bus        slave side of l2_way_array_if (flush, ready, read, rindex,
//                load, windex, wmask, datain, dataout)
//     dbg_sweep  1 while the FSM is in SWEEP (0 in IDLE)
//     dbg_ctr    current sweep counter
//
//   width must be a multiple of gran.
module l2_way_array #(
   parameter int s_index  = 3,
   parameter int width    = 32,
   parameter int num_ways = 4,
   parameter int gran     = 8
) (
   input  logic                clk,
   input  logic                rst,
   l2_way_array_if.slave       bus,
   output logic                dbg_sweep,
   output logic [s_index-1:0]  dbg_ctr
);
   localparam int num_sets  = 2 ** s_index;
   localparam int num_lanes = width / gran;

   typedef enum logic {
      SWEEP = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [s_index-1:0]   ctr;
   logic [s_index-1:0]   ctr_next;

   logic [width-1:0]           mem     [num_ways][num_sets];
   logic [width-1:0]           merged  [num_ways];
   logic [width-1:0]           rd_data [num_ways];
   logic [num_ways*width-1:0]  dataout_q;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SWEEP;
         ctr   <= '0;
      end else begin
         state <= state_next;
         ctr   <= ctr_next;
      end
   end

   always_comb begin
      state_next = state;
      ctr_next   = ctr;
      case (state)
         SWEEP: begin
            // The counter wraps to 0 on the last set. That edge is also
            // the SWEEP -> IDLE transition, so ctr is 0 again for the next sweep.
            ctr_next = ctr + 1'b1;
            if (ctr == {s_index{1'b1}}) begin
               state_next = IDLE;
            end
         end
         IDLE: begin
            if (bus.flush) begin
               state_next = SWEEP;
               ctr_next   = '0;
            end
         end
         default: begin
            state_next = SWEEP;
            ctr_next   = '0;
         end
      endcase
   end

   // ready is a function of the registered state, so it is itself glitch-free
   // and low from the first edge of reset until the sweep finishes.
   assign bus.ready = (state == IDLE);
   assign dbg_sweep = (state == SWEEP);
   assign dbg_ctr   = ctr;

   // ------------------------------------------------- write merge / read mux
   // merged[w] is the value entry[w][windex] would hold after a masked write.
   // It drives the array write port and also the same-index read bypass.
   // With an all-zero mask it is the unchanged old value.
   always_comb begin
      for (int w = 0; w < num_ways; w++) begin
         merged[w] = mem[w][bus.windex];
         for (int l = 0; l < num_lanes; l++) begin
            if (bus.wmask[l]) begin
               merged[w][l*gran +: gran] = bus.datain[l*gran +: gran];
            end
         end
         if (bus.load[w] && (bus.rindex == bus.windex)) begin
            rd_data[w] = merged[w];
         end else begin
            rd_data[w] = mem[w][bus.rindex];
         end
      end
   end

   // ------------------------------------------------------------ storage
   // The array has no reset of its own; the sweep that follows reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == SWEEP) begin
            for (int w = 0; w < num_ways; w++) begin
               mem[w][ctr] <= '0;
            end
         end else begin
            // A load that coincides with flush still lands here. The sweep
            // that starts on this edge then clears it.
            for (int w = 0; w < num_ways; w++) begin
               if (bus.load[w]) begin
                  mem[w][bus.windex] <= merged[w];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ read port
   always_ff @(posedge clk) begin
      if (rst) begin
         dataout_q <= '0;
      end else if ((state == IDLE) && bus.read) begin
         for (int w = 0; w < num_ways; w++) begin
            dataout_q[w*width +: width] <= rd_data[w];
         end
      end
   end

   assign bus.dataout = dataout_q;

endmodule

// File: tb/tb_l2_way_array.sv
// tb_l2_way_array
//   Directed bench for l2_way_array (s_index=3, width=32, num_ways=4, gran=8).
//   Drivers push the expected read data for every accepted read. A monitor
//   pops an entry after each edge on which read was accepted and compares it
//   with dataout. ready and hold behaviour are checked inline by the main sequence.
module tb_l2_way_array;
   localparam int SI = 3;
   localparam int WD = 32;
   localparam int NW = 4;
   localparam int GR = 8;
   localparam int DW = NW * WD;

   logic clk;
   logic rst;
   logic dbg_sweep;
   logic [SI-1:0] dbg_ctr;

   l2_way_array_if #(.s_index(SI), .width(WD), .num_ways(NW), .gran(GR)) bus ();

   l2_way_array #(.s_index(SI), .width(WD), .num_ways(NW), .gran(GR)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_sweep (dbg_sweep),
      .dbg_ctr   (dbg_ctr)
   );

   // ------------------------------------------------ clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------ scoreboard state
   logic [DW-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] all4(input logic [WD-1:0] v);
      return {v, v, v, v};
   endfunction

   // ------------------------------------------------ monitor
   logic          mon_fire;
   logic [DW-1:0] mon_exp;
   always @(posedge clk) begin
      mon_fire = bus.read && bus.ready && !rst;
      #1;
      if (mon_fire) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected: got %h expected no read response", bus.dataout);
         end else begin
            mon_exp = exp_q.pop_front();
            check("rd_data", bus.dataout, mon_exp);
         end
      end
   end

   // ------------------------------------------------ driver tasks
   task automatic drive(input logic rd, input logic [SI-1:0] ri, input logic [NW-1:0] ld,
                        input logic [SI-1:0] wi, input logic [NW-1:0] wm,
                        input logic [WD-1:0] di, input logic fl);
      @(negedge clk);
      bus.read   = rd;
      bus.rindex = ri;
      bus.load   = ld;
      bus.windex = wi;
      bus.wmask  = wm;
      bus.datain = di;
      bus.flush  = fl;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic wr(input logic [NW-1:0] ld, input logic [SI-1:0] wi,
                     input logic [NW-1:0] wm, input logic [WD-1:0] di);
      drive(1'b0, '0, ld, wi, wm, di, 1'b0);
   endtask

   task automatic rd(input logic [SI-1:0] ri, input logic [DW-1:0] exp);
      exp_q.push_back(exp);
      drive(1'b1, ri, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         after_edge();
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ------------------------------------------------ stimulus
   initial begin
      rst        = 1'b1;
      bus.read   = 1'b0;
      bus.rindex = '0;
      bus.load   = '0;
      bus.windex = '0;
      bus.wmask  = '0;
      bus.datain = '0;
      bus.flush  = 1'b0;

      // Reset sequencing
      repeat (2) after_edge();
      check("rst_ready", DW'(bus.ready), DW'(0));
      check("rst_dataout", bus.dataout, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         after_edge();
         check("init_ready", DW'(bus.ready), DW'(i == 8));
         check("init_dataout", bus.dataout, '0);
      end
      for (int i = 0; i < 8; i++) rd(SI'(i), '0);

      // Masked write
      wr(4'b0010, 3'd5, 4'b1111, 32'h11223344);
      wr(4'b0010, 3'd5, 4'b0101, 32'hAABBCCDD);
      rd(3'd5, {32'h0, 32'h0, 32'h11BB33DD, 32'h0});

      // Same-index bypass, then a plain re-read and a zero-mask load
      wr(4'b1111, 3'd2, 4'b1111, 32'h22222222);
      exp_q.push_back({32'hCAFEF00D, 32'h22222222, 32'h22222222, 32'hCAFEF00D});
      drive(1'b1, 3'd2, 4'b1001, 3'd2, 4'b1111, 32'hCAFEF00D, 1'b0);
      rd(3'd2, {32'hCAFEF00D, 32'h22222222, 32'h22222222, 32'hCAFEF00D});
      exp_q.push_back({32'hCAFEF00D, 32'h22222222, 32'h22222222, 32'hCAFEF00D});
      drive(1'b1, 3'd2, 4'b0100, 3'd2, 4'b0000, 32'hDEADBEEF, 1'b0);
      rd(3'd2, {32'hCAFEF00D, 32'h22222222, 32'h22222222, 32'hCAFEF00D});

      // Different-index write and read in one cycle
      wr(4'b1111, 3'd4, 4'b1111, 32'h44444444);
      exp_q.push_back(all4(32'h44444444));
      drive(1'b1, 3'd4, 4'b1111, 3'd3, 4'b1111, 32'h33333333, 1'b0);
      rd(3'd3, all4(32'h33333333));
      drain();

      // Flush mid-operation
      for (int i = 0; i < 8; i++) wr(4'b1111, SI'(i), 4'b1111, 32'hFFFFFFFF);
      rd(3'd7, all4(32'hFFFFFFFF));
      rd(3'd0, all4(32'hFFFFFFFF));
      exp_q.push_back(all4(32'h12345678));
      drive(1'b1, 3'd7, 4'b1111, 3'd7, 4'b1111, 32'h12345678, 1'b1);
      after_edge();
      check("flush_ready_e0", DW'(bus.ready), DW'(0));
      for (int i = 1; i <= 8; i++) begin
         // flush stays high for part of the sweep; read/load are ignored
         drive(1'b1, SI'(i - 1), 4'b1111, 3'd7, 4'b1111, 32'hBAD0BAD0, i < 4);
         after_edge();
         check("flush_ready", DW'(bus.ready), DW'(i == 8));
         check("flush_hold", bus.dataout, all4(32'h12345678));
      end
      for (int i = 0; i < 8; i++) rd(SI'(i), '0);
      drain();

      // Reset mid-sweep
      wr(4'b1111, 3'd1, 4'b1111, 32'h5A5A5A5A);
      rd(3'd1, all4(32'h5A5A5A5A));
      drive(1'b0, '0, '0, '0, '0, '0, 1'b1);
      after_edge();
      check("sweep2_ready_e0", DW'(bus.ready), DW'(0));
      idle();
      for (int i = 1; i <= 4; i++) begin
         after_edge();
         check("sweep2_hold", bus.dataout, all4(32'h5A5A5A5A));
      end
      check("sweep2_ctr", DW'(dbg_ctr), DW'(4));
      check("sweep2_state", DW'(dbg_sweep), DW'(1));
      @(negedge clk);
      rst = 1'b1;
      after_edge();
      check("midrst_dataout", bus.dataout, '0);
      check("midrst_ctr", DW'(dbg_ctr), DW'(0));
      check("midrst_ready", DW'(bus.ready), DW'(0));
      @(negedge clk);
      rst        = 1'b0;
      bus.read   = 1'b1;
      bus.rindex = 3'd1;
      bus.load   = 4'b1111;
      bus.windex = 3'd1;
      bus.wmask  = 4'b1111;
      bus.datain = 32'h99999999;
      for (int i = 1; i <= 8; i++) begin
         after_edge();
         check("midrst_sweep_ready", DW'(bus.ready), DW'(i == 8));
         check("midrst_sweep_dataout", bus.dataout, '0);
      end
      rd(3'd1, '0);
      rd(3'd5, '0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/l2_way_array.md
Name: l2_way_array

Overview:
- Multi-way, parametrised register array for L2 tag, valid, dirty and LRU storage.
- Holds `num_ways` independent ways of `2**s_index` entries each. All ways share one read index and one write index.
- Each way has its own write enable. Writes are byte-masked (`gran`-bit lanes).
- Reads are registered and see same-cycle writes through a merged bypass.
- Clearing is done by a sequential sweep, one set per cycle, after reset or on a `flush` request. The cache controller uses `ready` to gate its first access.

Parameters:
- s_index, 3: index width; num_sets = 2**s_index.
- width, 32: bits per entry per way. Must be a multiple of gran.
- num_ways, 4: number of ways.
- gran, 8: write-mask lane width; num_lanes = width/gran.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  request a sweep that clears all entries of all ways.
- ready  out  1  high when the array accepts read and load.
- read  in  1  capture a read of rindex on this edge.
- rindex  in  s_index  read set index.
- load  in  num_ways  per-way write enable.
- windex  in  s_index  write set index.
- wmask  in  num_lanes  lane enables; bit i covers datain[i*gran +: gran].
- datain  in  width  write data, shared by all ways.
- dataout  out  num_ways*width  registered read data; way w is at [w*width +: width].

Behaviour:
- Reset is synchronous and active-high, on clock clk.
- States: SWEEP and IDLE. Sweep counter ctr is s_index bits.

- While rst is high, on each edge:
  - state <= SWEEP, ctr <= 0.
  - ready <= 0, dataout <= 0.
  - Array contents are not touched directly; the sweep clears them.

- SWEEP state, on each edge with rst low:
  - All ways at set ctr <= 0, and ctr <= ctr+1.
  - When ctr == num_sets-1, state <= IDLE and ready <= 1.
  - Result: ready rises exactly num_sets edges after the first edge with rst low.
  - read, load and flush are ignored. dataout holds.

- IDLE state, ready=1:
  - Read: if read=1, dataout way w <= entry[w][rindex] on the edge (1-cycle latency). If read=0, dataout holds its value.
  - Write: for each w with load[w]=1, lane i of entry[w][windex] <= datain lane i if wmask[i]=1. Lanes with wmask[i]=0 keep their value.
  - Bypass: if read, load[w] and rindex==windex all hold, dataout way w <= the post-write merged value (datain lanes where wmask is set, old lanes elsewhere). Ways with load[w]=0 return stored data.
  - load with wmask all zero is a no-op write. It still triggers the bypass path, which returns the unchanged old value.
  - flush=1: on the edge, state <= SWEEP, ctr <= 0, ready <= 0. A read or load in the same cycle is performed first; the sweep then clears it.

- Simultaneous and boundary cases:
  - rst overrides flush, read and load.
  - rst asserted mid-sweep restarts the sweep from ctr=0.
  - flush held high across the sweep does not restart it. Only flush sampled in IDLE starts a new sweep.
  - ctr wraps num_sets-1 -> 0 only at the SWEEP -> IDLE transition.
  - Different rindex and windex: the read returns pre-write data. The write completes in the same edge.
  - dataout is never X after reset; it is 0 until the first IDLE read.

Test Plan:
Configuration for all scenarios: s_index=3, width=32, num_ways=4, gran=8.
- Reset sequencing: rst high for 2 cycles, then low -> ready=0 for 8 edges and 1 after the 8th. dataout=0 throughout. A read of each index 0..7 then returns 0 in all ways.
- Masked write: load=4'b0010, windex=5, wmask=4'b0101, datain=0xAABBCCDD over an entry holding 0x11223344. Reading index 5 next -> way1=0x11BB33DD, other ways 0.
- Same-index bypass: read=1, rindex=windex=2, load=4'b1001, wmask=4'b1111, datain=0xCAFEF00D -> next cycle way0 and way3 = 0xCAFEF00D, ways 1 and 2 hold stored values. Repeating the read without load returns the same values.
- Different-index write: windex=3, rindex=4 in the same cycle -> read returns the old index-4 data. A read of index 3 next cycle returns the new data.
- Flush mid-operation: fill all ways at all indices with 0xFFFFFFFF, then assert flush together with a load of index 7 -> ready=0 for 8 edges. Afterwards every entry reads 0, including index 7.
- Reset mid-sweep: assert rst at sweep ctr=4 -> the sweep restarts and ready rises 8 edges after rst deasserts. read and load issued while ready=0 leave contents and dataout unchanged.
